addr_gen_s1_pipe: RTL and testbench
===================================

Name: addr_gen_s1_pipe

Overview:
- Parametrised successor to the first address-generation stage.
- Computes effective address EA = base + (index << scale) + sext(disp) and linear address LA = (seg << SEG_SHIFT) + EA.
- Carries decode sideband (op, imm, flags, sr1) alongside the addresses through a PIPE_DEPTH-stage valid/ready pipeline with flush.
- Sits between decode/register-read and the AG2/memory-access stage.

Parameters:
- ADDR_W, 32, width of base/index/disp/EA/LA.
- SEG_W, 16, width of segment selector/base value.
- SEG_SHIFT, 16, left shift applied to the segment value before the add.
- IMM_W, 48, immediate width carried as sideband.
- PIPE_DEPTH, 1, register stages; legal values 1 or 2. With 2, EA is registered in stage A and LA is computed in stage B.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_valid  in  1  upstream op valid
- o_ready  out  1  block can accept an op this cycle
- i_flush  in  1  kill all in-flight ops
- i_sr1, i_sr2  in  3 each  source register ids; bypassed combinationally to o_sr1_byp/o_sr2_byp
- i_base_val, i_index_val  in  ADDR_W each  register-file values
- i_use_base, i_use_index  in  1 each  operand enables; a disabled operand contributes 0
- i_scale  in  2  index shift 0..3
- i_disp  in  ADDR_W  raw displacement
- i_disp_size  in  2  00: 8b sign-extended; 01: full width; 10 and 11: no disp (treated as 0)
- i_seg_val  in  SEG_W  segment value
- i_imm  in  IMM_W  immediate
- i_imm_size  in  2  immediate size code, passed through
- i_op  in  2  op code, passed through
- i_far_jmp, i_is_addrbd, i_is_o1mem, i_is_o2mem  in  1 each  flags, passed through
- o_sr1_byp, o_sr2_byp  out  3 each  combinational copies of i_sr1/i_sr2
- o_valid  out  1  output op valid
- i_ready  in  1  downstream accepts
- o_ea  out  ADDR_W  effective address
- o_la  out  ADDR_W  linear address
- o_la_wrap  out  1  carry out of the LA add (address wrap)
- o_sr1  out  3  registered sr1
- o_side  out  IMM_W+9  packed sideband {far_jmp, addrbd, o1mem, o2mem, imm_size, op, imm}
- o_base_val, o_index_val  out  ADDR_W each  registered operand values for AG2

Behaviour:
- Reset values: all stage valid bits 0; all datapath outputs 0.
- Arithmetic is modulo 2^ADDR_W.
  - disp extension: 8b mode sign-extends i_disp[7]; full-width mode uses i_disp as is.
  - Scaled index = index << i_scale, truncated to ADDR_W.
  - o_la_wrap = carry out of bit ADDR_W-1 of (seg<<SEG_SHIFT) + EA. The EA add carry is discarded.
- PIPE_DEPTH=1:
  - EA, LA and sideband all registered on acceptance.
  - Latency 1 cycle. o_ready = !o_valid || i_ready.
- PIPE_DEPTH=2:
  - Stage A registers EA, seg and sideband. Stage B registers LA and wrap; EA, seg and sideband are copied forward.
  - Stage B loads when !vB || i_ready.
  - Stage A loads when !vA || (stage B loads).
  - o_ready = !vA || (stage B loads). Latency 2 cycles.
  - Bubbles collapse: a valid op in A advances into an empty B regardless of i_ready.
- Handshake:
  - Accept = i_valid && o_ready.
  - Output transfer = o_valid && i_ready.
  - While o_valid && !i_ready, every output is held stable.
  - Simultaneous transfer-out and accept in the same cycle is legal and loses no ops (full throughput, one op per cycle).
- Flush:
  - i_flush clears all valid bits next cycle and overrides any acceptance in that cycle.
  - Data registers may keep stale values.
- rst has priority over i_flush and over acceptance.
- Reset or flush asserted mid-stall: the held op is dropped and o_valid=0 next cycle.
- Illegal PIPE_DEPTH is a compile-time error (generate-time assertion).

Decomposition:
- Shared package addr_gen_pkg:
  - disp_size encodings (DISP8, DISP32, DISP_NONE).
  - Sideband field offsets, sideband width function.
  - Scale width.
- Sub-module ag_stage_reg: a single parametrised valid/data pipeline register with load, flush and reset. Instantiated once per stage.
- The combinational EA/LA adders stay in the top.

Test Plan:
- Depth 1: base=0x1000, index=0x10, scale=2, disp=0x80 (8b), seg=0x0020, use_base=use_index=1 -> one cycle later o_valid=1, o_ea=0x00000FC0, o_la=0x00200FC0, o_la_wrap=0.
- Full-width disp=0xFFFFFFFF, base=1, no index, seg=0xFFFF -> o_ea=0x00000000, o_la=0xFFFF0000, wrap=0. Then seg=0xFFFF, base=0x00010000, disp none -> o_la=0x00000000, wrap=1.
- Backpressure, depth 2: stream 4 ops with i_ready=0 for 3 cycles -> o_ready falls after 2 ops accepted, outputs held stable; release i_ready -> all 4 ops emerge in order, one per cycle, no drop or duplicate.
- Flush with both stages valid and i_valid=1 in the same cycle -> o_valid=0 next cycle; the op offered during the flush is not accepted; next op after the flush passes normally.
- Reset asserted mid-stall (o_valid=1, i_ready=0), held 1 cycle -> o_valid=0, o_ea=0, o_side=0; o_ready=1 next cycle.
- Sideband and bypass: imm=0xABCDEF012345, op=2, imm_size=3, far_jmp=1, sr1=5 -> o_side fields and o_sr1=5 match after the latency; o_sr1_byp tracks i_sr1 in the same cycle.

Source files
------------

// File: rtl/addr_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addr_gen_pkg
//  Description : Shared definitions for the AG1 address-generation stage.
//                Holds the displacement-size encodings, the scale width, and
//                helpers that give the bit offsets of every field in the
//                packed sideband word, so producers and consumers of o_side
//                agree on the layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package addr_gen_pkg;

    // Index shift amount is 0..3.
    localparam int c_scale_w = 2;

    // Displacement size codes. 2'b11 is treated exactly like DISP_NONE.
    typedef enum logic [1:0] {
        DISP8         = 2'b00,
        DISP32        = 2'b01,
        DISP_NONE     = 2'b10,
        DISP_NONE_ALT = 2'b11
    } disp_size_e;

    // Sideband layout, LSB first:
    //   [imm_w-1:0] imm, then op (2), imm_size (2), o2mem, o1mem, addrbd,
    //   far_jmp, and one spare MSB that always reads 0.
    function automatic int side_op_lsb(input int imm_w);
        return imm_w;
    endfunction

    function automatic int side_isz_lsb(input int imm_w);
        return imm_w + 2;
    endfunction

    function automatic int side_o2mem_bit(input int imm_w);
        return imm_w + 4;
    endfunction

    function automatic int side_o1mem_bit(input int imm_w);
        return imm_w + 5;
    endfunction

    function automatic int side_addrbd_bit(input int imm_w);
        return imm_w + 6;
    endfunction

    function automatic int side_far_bit(input int imm_w);
        return imm_w + 7;
    endfunction

    function automatic int side_w(input int imm_w);
        return imm_w + 9;
    endfunction

endpackage : addr_gen_pkg
`default_nettype wire

// File: rtl/ag_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : ag_stage_reg
//  Description : One valid/data pipeline register.
//                  clk, rst    - clock, synchronous active-high reset
//                  i_flush     - clear valid next cycle (beats i_load)
//                  i_load      - stage may take a new value this cycle
//                  i_valid     - valid bit of the incoming value
//                  i_data      - incoming payload
//                  o_valid     - registered valid bit
//                  o_data      - registered payload
//                Reset zeroes both valid and payload. Flush only clears the
//                valid bit; the payload may keep a stale value.
//  Revision    : 1.0 - initial release
// ============================================================================
module ag_stage_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_load,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (i_load) begin
                r_valid <= i_valid;
            end
            // Payload only moves when a real op arrives, so an idle load
            // does not disturb the datapath registers.
            if (i_load && i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule : ag_stage_reg
`default_nettype wire

// File: rtl/addr_gen_s1_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : addr_gen_s1_pipe
//  Description : First address-generation stage.
//                  EA = base + (index << scale) + ext(disp)   (mod 2^ADDR_W)
//                  LA = (seg << SEG_SHIFT) + EA, o_la_wrap = carry out
//                Decode sideband travels with the addresses through a
//                PIPE_DEPTH (1 or 2) stage valid/ready pipeline with flush.
//                With two stages EA is registered first and LA is formed
//                from the registered EA/seg in the second stage.
//  Ports       : clk/rst, i_valid/o_ready (upstream), o_valid/i_ready
//                (downstream), i_flush, operand inputs (base, index, scale,
//                disp, seg), sideband inputs (imm, imm_size, op, flags, sr1),
//                o_sr1_byp/o_sr2_byp (combinational), and the registered
//                o_ea, o_la, o_la_wrap, o_sr1, o_side, o_base_val,
//                o_index_val.
//  Revision    : 1.0 - initial release
// ============================================================================
module addr_gen_s1_pipe
    import addr_gen_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int SEG_W      = 16,
    parameter int SEG_SHIFT  = 16,
    parameter int IMM_W      = 48,
    parameter int PIPE_DEPTH = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic                      i_flush,
    input  logic [2:0]                i_sr1,
    input  logic [2:0]                i_sr2,
    input  logic [ADDR_W-1:0]         i_base_val,
    input  logic [ADDR_W-1:0]         i_index_val,
    input  logic                      i_use_base,
    input  logic                      i_use_index,
    input  logic [c_scale_w-1:0]      i_scale,
    input  logic [ADDR_W-1:0]         i_disp,
    input  logic [1:0]                i_disp_size,
    input  logic [SEG_W-1:0]          i_seg_val,
    input  logic [IMM_W-1:0]          i_imm,
    input  logic [1:0]                i_imm_size,
    input  logic [1:0]                i_op,
    input  logic                      i_far_jmp,
    input  logic                      i_is_addrbd,
    input  logic                      i_is_o1mem,
    input  logic                      i_is_o2mem,
    output logic [2:0]                o_sr1_byp,
    output logic [2:0]                o_sr2_byp,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [ADDR_W-1:0]         o_ea,
    output logic [ADDR_W-1:0]         o_la,
    output logic                      o_la_wrap,
    output logic [2:0]                o_sr1,
    output logic [side_w(IMM_W)-1:0]  o_side,
    output logic [ADDR_W-1:0]         o_base_val,
    output logic [ADDR_W-1:0]         o_index_val
);

    localparam int SIDE_W     = side_w(IMM_W);
    localparam int OP_LSB     = side_op_lsb(IMM_W);
    localparam int ISZ_LSB    = side_isz_lsb(IMM_W);
    localparam int O2MEM_BIT  = side_o2mem_bit(IMM_W);
    localparam int O1MEM_BIT  = side_o1mem_bit(IMM_W);
    localparam int ADDRBD_BIT = side_addrbd_bit(IMM_W);
    localparam int FAR_BIT    = side_far_bit(IMM_W);

    typedef struct packed {
        logic [ADDR_W-1:0] ea;
        logic [SEG_W-1:0]  seg;
        logic [SIDE_W-1:0] side;
        logic [2:0]        sr1;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] index;
    } stage_a_t;

    typedef struct packed {
        logic [ADDR_W-1:0] la;
        logic              wrap;
        logic [ADDR_W-1:0] ea;
        logic [SIDE_W-1:0] side;
        logic [2:0]        sr1;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] index;
    } out_t;

    // LA sum with the carry kept in the extra MSB.
    function automatic logic [ADDR_W:0] f_la(input logic [SEG_W-1:0]  seg,
                                             input logic [ADDR_W-1:0] ea);
        logic [ADDR_W-1:0] seg_sh;
        seg_sh = ADDR_W'(seg) << SEG_SHIFT;
        return {1'b0, seg_sh} + {1'b0, ea};
    endfunction

    // ------------------------------------------------------------------
    // Combinational EA and sideband packing
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_base_op;
    logic [ADDR_W-1:0] w_index_sh;
    logic [ADDR_W-1:0] w_disp_ext;
    logic [ADDR_W-1:0] w_ea;
    logic [SIDE_W-1:0] w_side;

    assign w_base_op  = i_use_base  ? i_base_val             : '0;
    assign w_index_sh = i_use_index ? (i_index_val << i_scale) : '0;

    always_comb begin
        w_disp_ext = '0;
        case (disp_size_e'(i_disp_size))
            DISP8:   w_disp_ext = {{(ADDR_W-8){i_disp[7]}}, i_disp[7:0]};
            DISP32:  w_disp_ext = i_disp;
            default: w_disp_ext = '0;
        endcase
    end

    // The EA carry is intentionally dropped: arithmetic wraps.
    assign w_ea = w_base_op + w_index_sh + w_disp_ext;

    always_comb begin
        w_side                      = '0;
        w_side[IMM_W-1:0]           = i_imm;
        w_side[OP_LSB +: 2]         = i_op;
        w_side[ISZ_LSB +: 2]        = i_imm_size;
        w_side[O2MEM_BIT]           = i_is_o2mem;
        w_side[O1MEM_BIT]           = i_is_o1mem;
        w_side[ADDRBD_BIT]          = i_is_addrbd;
        w_side[FAR_BIT]             = i_far_jmp;
    end

    assign o_sr1_byp = i_sr1;
    assign o_sr2_byp = i_sr2;

    // ------------------------------------------------------------------
    // Pipeline
    // ------------------------------------------------------------------
    out_t w_out;
    logic w_out_valid;
    logic w_ready;

    if (PIPE_DEPTH == 1) begin : g_depth1
        logic            w_load;
        logic [ADDR_W:0] w_la_sum;
        out_t            w_d;

        assign w_load   = !w_out_valid || i_ready;
        assign w_la_sum = f_la(i_seg_val, w_ea);
        assign w_d      = {w_la_sum[ADDR_W-1:0], w_la_sum[ADDR_W], w_ea,
                           w_side, i_sr1, i_base_val, i_index_val};
        assign w_ready  = w_load;

        ag_stage_reg #(
            .DATA_W ($bits(out_t))
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_flush (i_flush),
            .i_load  (w_load),
            .i_valid (i_valid),
            .i_data  (w_d),
            .o_valid (w_out_valid),
            .o_data  (w_out)
        );
    end else if (PIPE_DEPTH == 2) begin : g_depth2
        logic            w_va;
        logic            w_load_a;
        logic            w_load_b;
        stage_a_t        w_a_d;
        stage_a_t        w_a_q;
        logic [ADDR_W:0] w_la_sum;
        out_t            w_b_d;

        // B drains or fills whenever it is empty, which collapses bubbles
        // regardless of downstream ready.
        assign w_load_b = !w_out_valid || i_ready;
        assign w_load_a = !w_va || w_load_b;
        assign w_ready  = w_load_a;

        assign w_a_d    = {w_ea, i_seg_val, w_side, i_sr1, i_base_val,
                           i_index_val};
        assign w_la_sum = f_la(w_a_q.seg, w_a_q.ea);
        assign w_b_d    = {w_la_sum[ADDR_W-1:0], w_la_sum[ADDR_W], w_a_q.ea,
                           w_a_q.side, w_a_q.sr1, w_a_q.base, w_a_q.index};

        ag_stage_reg #(
            .DATA_W ($bits(stage_a_t))
        ) u_stage_a (
            .clk     (clk),
            .rst     (rst),
            .i_flush (i_flush),
            .i_load  (w_load_a),
            .i_valid (i_valid),
            .i_data  (w_a_d),
            .o_valid (w_va),
            .o_data  (w_a_q)
        );

        ag_stage_reg #(
            .DATA_W ($bits(out_t))
        ) u_stage_b (
            .clk     (clk),
            .rst     (rst),
            .i_flush (i_flush),
            .i_load  (w_load_b),
            .i_valid (w_va),
            .i_data  (w_b_d),
            .o_valid (w_out_valid),
            .o_data  (w_out)
        );
    end else begin : g_bad_depth
        $error("addr_gen_s1_pipe: PIPE_DEPTH must be 1 or 2");
    end

    assign o_ready     = w_ready;
    assign o_valid     = w_out_valid;
    assign o_ea        = w_out.ea;
    assign o_la        = w_out.la;
    assign o_la_wrap   = w_out.wrap;
    assign o_side      = w_out.side;
    assign o_sr1       = w_out.sr1;
    assign o_base_val  = w_out.base;
    assign o_index_val = w_out.index;

endmodule : addr_gen_s1_pipe
`default_nettype wire

// File: tb/tb_addr_gen_s1_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addr_gen_s1_pipe
//  Description : Self-checking bench. Drives one PIPE_DEPTH=1 and one
//                PIPE_DEPTH=2 instance from the same stimulus and compares
//                each against a queue-based reference: every accepted op is
//                stamped with its acceptance cycle and becomes visible at the
//                output once it is the oldest op and DEPTH cycles old.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addr_gen_s1_pipe;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        i_flush;
    logic [2:0]  i_sr1;
    logic [2:0]  i_sr2;
    logic [31:0] i_base_val;
    logic [31:0] i_index_val;
    logic        i_use_base;
    logic        i_use_index;
    logic [1:0]  i_scale;
    logic [31:0] i_disp;
    logic [1:0]  i_disp_size;
    logic [15:0] i_seg_val;
    logic [47:0] i_imm;
    logic [1:0]  i_imm_size;
    logic [1:0]  i_op;
    logic        i_far_jmp;
    logic        i_is_addrbd;
    logic        i_is_o1mem;
    logic        i_is_o2mem;
    logic        i_ready;

    logic [1:0]        ready_o;
    logic [1:0]        valid_o;
    logic [1:0]        wrap_o;
    logic [1:0][2:0]   byp1_o;
    logic [1:0][2:0]   byp2_o;
    logic [1:0][2:0]   sr1_o;
    logic [1:0][31:0]  ea_o;
    logic [1:0][31:0]  la_o;
    logic [1:0][31:0]  base_o;
    logic [1:0][31:0]  idx_o;
    logic [1:0][56:0]  side_o;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    typedef struct {
        logic [31:0] ea;
        logic [31:0] la;
        logic        wrap;
        logic [56:0] side;
        logic [2:0]  sr1;
        logic [31:0] base;
        logic [31:0] idx;
        int          t_acc;
    } exp_t;

    exp_t mq[2][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    addr_gen_s1_pipe #(.PIPE_DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(ready_o[0]),
        .i_flush(i_flush), .i_sr1(i_sr1), .i_sr2(i_sr2),
        .i_base_val(i_base_val), .i_index_val(i_index_val),
        .i_use_base(i_use_base), .i_use_index(i_use_index),
        .i_scale(i_scale), .i_disp(i_disp), .i_disp_size(i_disp_size),
        .i_seg_val(i_seg_val), .i_imm(i_imm), .i_imm_size(i_imm_size),
        .i_op(i_op), .i_far_jmp(i_far_jmp), .i_is_addrbd(i_is_addrbd),
        .i_is_o1mem(i_is_o1mem), .i_is_o2mem(i_is_o2mem),
        .o_sr1_byp(byp1_o[0]), .o_sr2_byp(byp2_o[0]), .o_valid(valid_o[0]),
        .i_ready(i_ready), .o_ea(ea_o[0]), .o_la(la_o[0]),
        .o_la_wrap(wrap_o[0]), .o_sr1(sr1_o[0]), .o_side(side_o[0]),
        .o_base_val(base_o[0]), .o_index_val(idx_o[0])
    );

    addr_gen_s1_pipe #(.PIPE_DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(ready_o[1]),
        .i_flush(i_flush), .i_sr1(i_sr1), .i_sr2(i_sr2),
        .i_base_val(i_base_val), .i_index_val(i_index_val),
        .i_use_base(i_use_base), .i_use_index(i_use_index),
        .i_scale(i_scale), .i_disp(i_disp), .i_disp_size(i_disp_size),
        .i_seg_val(i_seg_val), .i_imm(i_imm), .i_imm_size(i_imm_size),
        .i_op(i_op), .i_far_jmp(i_far_jmp), .i_is_addrbd(i_is_addrbd),
        .i_is_o1mem(i_is_o1mem), .i_is_o2mem(i_is_o2mem),
        .o_sr1_byp(byp1_o[1]), .o_sr2_byp(byp2_o[1]), .o_valid(valid_o[1]),
        .i_ready(i_ready), .o_ea(ea_o[1]), .o_la(la_o[1]),
        .o_la_wrap(wrap_o[1]), .o_sr1(sr1_o[1]), .o_side(side_o[1]),
        .o_base_val(base_o[1]), .o_index_val(idx_o[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference result of the op currently on the inputs.
    function automatic exp_t model_now();
        exp_t        e;
        logic [31:0] b;
        logic [31:0] x;
        logic [31:0] d;
        logic [32:0] s;
        b = i_use_base  ? i_base_val : 32'h0;
        x = i_use_index ? (i_index_val * (32'h1 << i_scale)) : 32'h0;
        case (i_disp_size)
            2'd0:    d = {{24{i_disp[7]}}, i_disp[7:0]};
            2'd1:    d = i_disp;
            default: d = 32'h0;
        endcase
        e.ea    = b + x + d;
        s       = 33'(i_seg_val) * 33'h10000 + 33'(e.ea);
        e.la    = s[31:0];
        e.wrap  = s[32];
        e.side  = {1'b0, i_far_jmp, i_is_addrbd, i_is_o1mem, i_is_o2mem,
                   i_imm_size, i_op, i_imm};
        e.sr1   = i_sr1;
        e.base  = i_base_val;
        e.idx   = i_index_val;
        e.t_acc = cyc;
        return e;
    endfunction

    // Entered at posedge+1 with inputs set; checks, clocks, updates model.
    task automatic step();
        exp_t e;
        bit   rdy [2];
        bit   vis [2];
        #1;
        e = model_now();
        for (int d = 0; d < 2; d++) begin
            rdy[d] = (mq[d].size() < d + 1) || i_ready;
            vis[d] = (mq[d].size() > 0) && (cyc >= mq[d][0].t_acc + d + 1);
            chk($sformatf("d%0d_sr1_byp", d + 1), 64'(byp1_o[d]), 64'(i_sr1));
            chk($sformatf("d%0d_sr2_byp", d + 1), 64'(byp2_o[d]), 64'(i_sr2));
            chk($sformatf("d%0d_ready", d + 1), 64'(ready_o[d]), 64'(rdy[d]));
            chk($sformatf("d%0d_valid", d + 1), 64'(valid_o[d]), 64'(vis[d]));
            if (vis[d]) begin
                chk($sformatf("d%0d_ea", d + 1),   64'(ea_o[d]),   64'(mq[d][0].ea));
                chk($sformatf("d%0d_la", d + 1),   64'(la_o[d]),   64'(mq[d][0].la));
                chk($sformatf("d%0d_wrap", d + 1), 64'(wrap_o[d]), 64'(mq[d][0].wrap));
                chk($sformatf("d%0d_side", d + 1), 64'(side_o[d]), 64'(mq[d][0].side));
                chk($sformatf("d%0d_sr1", d + 1),  64'(sr1_o[d]),  64'(mq[d][0].sr1));
                chk($sformatf("d%0d_base", d + 1), 64'(base_o[d]), 64'(mq[d][0].base));
                chk($sformatf("d%0d_idx", d + 1),  64'(idx_o[d]),  64'(mq[d][0].idx));
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst || i_flush) begin
                mq[d].delete();
            end else begin
                if (vis[d] && i_ready) void'(mq[d].pop_front());
                if (i_valid && rdy[d]) mq[d].push_back(e);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic rand_op();
        i_sr1       = 3'($urandom);
        i_sr2       = 3'($urandom);
        i_base_val  = $urandom;
        i_index_val = $urandom;
        i_use_base  = 1'($urandom);
        i_use_index = 1'($urandom);
        i_scale     = 2'($urandom);
        i_disp      = $urandom;
        i_disp_size = 2'($urandom);
        i_seg_val   = 16'($urandom);
        i_imm       = {16'($urandom), $urandom};
        i_imm_size  = 2'($urandom);
        i_op        = 2'($urandom);
        i_far_jmp   = 1'($urandom);
        i_is_addrbd = 1'($urandom);
        i_is_o1mem  = 1'($urandom);
        i_is_o2mem  = 1'($urandom);
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        rand_op();
        @(posedge clk);
        #1;

        // Reset state
        step();
        for (int d = 0; d < 2; d++) begin
            chk("rst_ea",    64'(ea_o[d]),    64'(32'h0));
            chk("rst_la",    64'(la_o[d]),    64'(32'h0));
            chk("rst_side",  64'(side_o[d]),  64'(57'h0));
            chk("rst_valid", 64'(valid_o[d]), 64'(1'b0));
        end
        rst = 1'b0;

        // 8-bit negative displacement, scaled index
        i_base_val = 32'h1000; i_index_val = 32'h10; i_scale = 2'd2;
        i_disp = 32'h80; i_disp_size = 2'b00; i_seg_val = 16'h0020;
        i_use_base = 1'b1; i_use_index = 1'b1; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        chk("tp1_d1_valid", 64'(valid_o[0]), 64'(1'b1));
        chk("tp1_d1_ea",    64'(ea_o[0]),    64'(32'h00000FC0));
        chk("tp1_d1_la",    64'(la_o[0]),    64'(32'h00200FC0));
        chk("tp1_d1_wrap",  64'(wrap_o[0]),  64'(1'b0));
        step();
        chk("tp1_d2_ea", 64'(ea_o[1]), 64'(32'h00000FC0));
        chk("tp1_d2_la", 64'(la_o[1]), 64'(32'h00200FC0));

        // Full-width displacement wrapping EA to zero
        i_base_val = 32'h1; i_use_index = 1'b0; i_disp = 32'hFFFFFFFF;
        i_disp_size = 2'b01; i_seg_val = 16'hFFFF; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        chk("tp2_d1_ea",   64'(ea_o[0]),   64'(32'h0));
        chk("tp2_d1_la",   64'(la_o[0]),   64'(32'hFFFF0000));
        chk("tp2_d1_wrap", 64'(wrap_o[0]), 64'(1'b0));
        step();

        // LA carry out, no displacement
        i_base_val = 32'h00010000; i_disp_size = 2'b10; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        chk("tp3_d1_la",   64'(la_o[0]),   64'(32'h0));
        chk("tp3_d1_wrap", 64'(wrap_o[0]), 64'(1'b1));
        step();
        chk("tp3_d2_la",   64'(la_o[1]),   64'(32'h0));
        chk("tp3_d2_wrap", 64'(wrap_o[1]), 64'(1'b1));
        step();
        step();

        // Backpressure: downstream stalled for 3 cycles then released
        for (int k = 0; k < 9; k++) begin
            rand_op();
            i_ready = (k >= 3);
            i_valid = (k < 5);
            step();
            if (k == 1) chk("bp_d2_ready_low", 64'(ready_o[1]), 64'(1'b0));
        end
        i_valid = 1'b0; i_ready = 1'b1;
        repeat (3) step();

        // Flush with both stages full and an op offered
        i_ready = 1'b0; i_valid = 1'b1;
        rand_op(); step();
        rand_op(); step();
        rand_op(); i_flush = 1'b1; step();
        i_flush = 1'b0;
        chk("fl_d1_valid", 64'(valid_o[0]), 64'(1'b0));
        chk("fl_d2_valid", 64'(valid_o[1]), 64'(1'b0));
        i_ready = 1'b1; rand_op(); step();
        i_valid = 1'b0; step();
        chk("fl_d2_next_valid", 64'(valid_o[1]), 64'(1'b1));
        step();

        // Reset while stalled
        i_ready = 1'b0; i_valid = 1'b1; rand_op(); step();
        i_valid = 1'b0; step();
        rst = 1'b1; step();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("rs_valid", 64'(valid_o[d]), 64'(1'b0));
            chk("rs_ea",    64'(ea_o[d]),    64'(32'h0));
            chk("rs_side",  64'(side_o[d]),  64'(57'h0));
            chk("rs_ready", 64'(ready_o[d]), 64'(1'b1));
        end

        // Sideband and bypass
        i_ready = 1'b1; rand_op();
        i_imm = 48'hABCDEF012345; i_op = 2'd2; i_imm_size = 2'd3;
        i_far_jmp = 1'b1; i_is_addrbd = 1'b0; i_is_o1mem = 1'b0;
        i_is_o2mem = 1'b0; i_sr1 = 3'd5; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        chk("sb_d1_side", 64'(side_o[0]), 64'({1'b0, 1'b1, 3'b000, 2'd3, 2'd2, 48'hABCDEF012345}));
        chk("sb_d1_sr1",  64'(sr1_o[0]),  64'(3'd5));
        step();
        chk("sb_d2_side", 64'(side_o[1]), 64'({1'b0, 1'b1, 3'b000, 2'd3, 2'd2, 48'hABCDEF012345}));
        chk("sb_d2_sr1",  64'(sr1_o[1]),  64'(3'd5));
        step();

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            rand_op();
            i_valid = ($urandom_range(99) < 70);
            i_ready = ($urandom_range(99) < 70);
            i_flush = ($urandom_range(99) < 4);
            rst     = ($urandom_range(99) < 2);
            step();
        end
        rst = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_addr_gen_s1_pipe
`default_nettype wire
